router_fsm_nch: RTL and testbench

Parametrised packet-router control FSM for NUM_CH output channels. Sits between the input register/parity block and the per-channel FIFOs and synchroniser. Decodes the destination address from the header byte and sequences header, payload and parity loads into the selected FIFO. Adds three behaviours over the fixed 3-channel controller:

- per-channel full/empty/soft-reset vectors;
- invalid-address packet dropping;
- a bounded wait-for-empty timeout.

---
 rtl/router_fsm_nch_pkg.sv | 27 ++
 rtl/router_fsm_nch_if.sv | 45 ++++
 rtl/router_wait_timer.sv | 36 +++
 rtl/router_fsm_nch.sv | 132 +++++++++++++
 tb/tb_router_fsm_nch.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_fsm_nch_pkg.sv
// router_pkg: shared types and helpers for the NUM_CH packet-router controller.
//   router_state_t : 4-bit FSM state encoding
//   addr_valid()   : header address range check against the channel count
//   addr_width()   : header address field width for a channel count (min 1)
package router_pkg;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } router_state_t;

    function automatic logic addr_valid(input logic [31:0] a, input int unsigned num_ch);
        return (a < num_ch);
    endfunction

    function automatic int addr_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if: handshake/status bundle between the router controller
// and its surroundings (input register block, channel FIFOs, synchroniser).
//   master : environment side - drives framing, data and FIFO status
//   slave  : controller side  - drives the state decodes, addr_q and timeout
interface router_fsm_nch_if
    import router_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = addr_width(NUM_CH),
    parameter int DATA_W = 8
);
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_pkt_valid;

    logic              busy;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              drop_state;
    logic [ADDR_W-1:0] addr_q;
    logic              timeout;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, drop_state, addr_q, timeout
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, drop_state, addr_q, timeout
    );
endinterface

// File: rtl/router_wait_timer.sv
// router_wait_timer: bounded cycle counter for the wait-for-empty state.
//   clock, reset_n : clock / async active-low reset
//   clear_i        : force the count to zero (held while not waiting)
//   enable_i       : count this cycle; saturates at WAIT_MAX-1
//   expired_o      : enabled and the count has reached WAIT_MAX-1
// WAIT_MAX = 0 disables expiry entirely.
module router_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CNT_W = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_MAX == 0) ? '0 : CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear_i)
            wait_cnt_d = '0;
        else if (enable_i && (wait_cnt_q != CNT_LAST))
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wait_cnt_q <= '0;
        else          wait_cnt_q <= wait_cnt_d;
    end

    assign expired_o = (WAIT_MAX != 0) && enable_i && (wait_cnt_q == CNT_LAST);

endmodule

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: packet-router control FSM for NUM_CH output channels.
// Decodes the destination from the header byte, sequences header/payload/
// parity loads into the selected FIFO, drops packets to invalid channels and
// gives up waiting on a non-empty FIFO after WAIT_MAX cycles.
//   clock, reset_n : clock / async active-low reset
//   bus (slave)    : pkt_valid, data_in, per-channel fifo_full/fifo_empty/
//                    soft_reset, parity_done, low_pkt_valid in;
//                    Moore state decodes, addr_q and timeout pulse out
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = addr_width(NUM_CH),
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    router_fsm_nch_if.slave bus
);
    router_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              timeout_q, timeout_d;

    logic [ADDR_W-1:0] hdr_a;
    logic              hdr_ok;
    logic              empty_hdr;
    logic              full_sel, empty_sel, srst_sel;
    logic              wait_expired;

    assign hdr_a  = bus.data_in[ADDR_W-1:0];
    assign hdr_ok = addr_valid(32'(hdr_a), NUM_CH);

    // Channel selects as explicit muxes: addr_q may hold an out-of-range
    // address after a dropped header, which must read as all-zero status.
    always_comb begin
        empty_hdr = 1'b0;
        full_sel  = 1'b0;
        empty_sel = 1'b0;
        srst_sel  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hdr_a == ADDR_W'(i)) empty_hdr = bus.fifo_empty[i];
            if (addr_q == ADDR_W'(i)) begin
                full_sel  = bus.fifo_full[i];
                empty_sel = bus.fifo_empty[i];
                srst_sel  = bus.soft_reset[i];
            end
        end
    end

    router_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (state_q != WAIT_TILL_EMPTY),
        .enable_i  (state_q == WAIT_TILL_EMPTY),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    addr_d = hdr_a;
                    if (!hdr_ok)        state_d = DROP_PACKET;
                    else if (empty_hdr) state_d = LOAD_FIRST_DATA;
                    else                state_d = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (full_sel)           state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!full_sel) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                // Empty is checked first so it wins over a same-cycle expiry.
                if (empty_sel)         state_d = LOAD_FIRST_DATA;
                else if (wait_expired) state_d = DROP_PACKET;
            end
            DROP_PACKET: begin
                if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // Soft reset of the owning channel aborts any in-flight packet.
        if ((state_q != DECODE_ADDRESS) && srst_sel)
            state_d = DECODE_ADDRESS;

        timeout_d = (state_q == WAIT_TILL_EMPTY) && (state_d == DROP_PACKET);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DECODE_ADDRESS;
            addr_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.drop_state    = (state_q == DROP_PACKET);
    assign bus.write_enb_reg = (state_q == LOAD_FIRST_DATA) || (state_q == LOAD_DATA) ||
                               (state_q == LOAD_AFTER_FULL) || (state_q == LOAD_PARITY);
    assign bus.busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA) ||
                                 (state_q == DROP_PACKET));
    assign bus.addr_q        = addr_q;
    assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
module tb_router_fsm_nch;
    // Output vector order: {busy, detect_add, lfd, ld, laf, full, wen, rst_int, drop}
    localparam logic [8:0] S_DEC  = 9'b0_1_0_0_0_0_0_0_0;
    localparam logic [8:0] S_LFD  = 9'b1_0_1_0_0_0_1_0_0;
    localparam logic [8:0] S_LD   = 9'b0_0_0_1_0_0_1_0_0;
    localparam logic [8:0] S_LAF  = 9'b1_0_0_0_1_0_1_0_0;
    localparam logic [8:0] S_FULL = 9'b1_0_0_0_0_1_0_0_0;
    localparam logic [8:0] S_LP   = 9'b1_0_0_0_0_0_1_0_0;
    localparam logic [8:0] S_CPE  = 9'b1_0_0_0_0_0_0_1_0;
    localparam logic [8:0] S_WAIT = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] S_DROP = 9'b0_0_0_0_0_0_0_0_1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    router_fsm_nch_if #(.NUM_CH(3)) bus ();
    router_fsm_nch_if #(.NUM_CH(3)) bus2 ();

    router_fsm_nch #(.NUM_CH(3), .WAIT_MAX(16)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));
    router_fsm_nch #(.NUM_CH(3), .WAIT_MAX(1)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2));

    logic [8:0] o1, o2;
    assign o1 = {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                 bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.drop_state};
    assign o2 = {bus2.busy, bus2.detect_add, bus2.lfd_state, bus2.ld_state, bus2.laf_state,
                 bus2.full_state, bus2.write_enb_reg, bus2.rst_int_reg, bus2.drop_state};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({o1, bus.addr_q, bus.timeout} !== {S_DEC, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%b/%0d/%b exp=%b/0/0", o1, bus.addr_q, bus.timeout, S_DEC);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++;
        if (o1 !== S_DEC) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", o1, S_DEC);
        end
    endtask

    task automatic test_basic();
        logic [8:0] exp [8];
        int wen_cnt;
        exp = '{S_LFD, S_LD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DEC};
        wen_cnt = 0;
        bus.fifo_empty = 3'b111;
        for (int i = 0; i < 8; i++) begin
            bus.pkt_valid = (i < 5);
            bus.data_in   = (i == 0) ? 8'h01 : 8'(8'hA0 + i);
            tick();
            if (bus.write_enb_reg) wen_cnt++;
            checks++;
            if (o1 !== exp[i]) begin
                failures++;
                $display("FAIL basic_seq step=%0d got=%b exp=%b", i, o1, exp[i]);
            end
        end
        checks++;
        if (bus.addr_q !== 2'd1) begin
            failures++;
            $display("FAIL basic_addr got=%0d exp=1", bus.addr_q);
        end
        checks++;
        if (wen_cnt != 6) begin
            failures++;
            $display("FAIL basic_wen_cycles got=%0d exp=6", wen_cnt);
        end
    endtask

    task automatic test_drop();
        logic [8:0] exp [4];
        exp = '{S_DROP, S_DROP, S_DROP, S_DEC};
        for (int i = 0; i < 4; i++) begin
            bus.pkt_valid = (i < 3);
            bus.data_in   = (i == 0) ? 8'h03 : 8'h55;
            tick();
            checks++;
            if (o1 !== exp[i]) begin
                failures++;
                $display("FAIL drop_seq step=%0d got=%b exp=%b", i, o1, exp[i]);
            end
            if (i == 0) begin
                checks++;
                if (bus.addr_q !== 2'd3) begin
                    failures++;
                    $display("FAIL drop_addr got=%0d exp=3", bus.addr_q);
                end
            end
        end
    endtask

    task automatic test_wait_timeout();
        int pulses;
        pulses = 0;
        bus.fifo_empty = 3'b011;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 8'h02;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            if (bus.timeout) pulses++;
            checks++;
            if ({o1, bus.timeout} !== {S_WAIT, 1'b0}) begin
                failures++;
                $display("FAIL wait_hold cyc=%0d got=%b/%b exp=%b/0", i, o1, bus.timeout, S_WAIT);
            end
            bus.data_in = 8'h77;
        end
        tick();
        if (bus.timeout) pulses++;
        checks++;
        if ({o1, bus.timeout} !== {S_DROP, 1'b1}) begin
            failures++;
            $display("FAIL wait_expire got=%b/%b exp=%b/1", o1, bus.timeout, S_DROP);
        end
        tick();
        if (bus.timeout) pulses++;
        bus.pkt_valid = 1'b0;
        tick();
        if (bus.timeout) pulses++;
        checks++;
        if ({o1, pulses} !== {S_DEC, 32'd1}) begin
            failures++;
            $display("FAIL wait_after got=%b pulses=%0d exp=%b pulses=1", o1, pulses, S_DEC);
        end
        bus.fifo_empty = 3'b111;
    endtask

    task automatic test_wait_max1();
        bus2.fifo_empty = 3'b011;
        bus2.pkt_valid  = 1'b1;
        bus2.data_in    = 8'h02;
        tick();
        tick();
        checks++;
        if ({o2, bus2.timeout} !== {S_DROP, 1'b1}) begin
            failures++;
            $display("FAIL wmax1_timeout got=%b/%b exp=%b/1", o2, bus2.timeout, S_DROP);
        end
        bus2.pkt_valid = 1'b0;
        tick();
        // Empty arriving in the expiry cycle must win.
        bus2.pkt_valid = 1'b1;
        tick();
        bus2.fifo_empty = 3'b111;
        tick();
        checks++;
        if ({o2, bus2.timeout} !== {S_LFD, 1'b0}) begin
            failures++;
            $display("FAIL wmax1_empty_wins got=%b/%b exp=%b/0", o2, bus2.timeout, S_LFD);
        end
        bus2.pkt_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_full();
        logic [8:0] exp [10];
        logic [2:0] full_v [10];
        logic       pv_v [10];
        exp    = '{S_LFD, S_LD, S_FULL, S_FULL, S_FULL, S_LAF, S_LD, S_LP, S_CPE, S_DEC};
        full_v = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        pv_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.data_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            bus.fifo_full = full_v[i];
            bus.pkt_valid = pv_v[i];
            tick();
            checks++;
            if (o1 !== exp[i]) begin
                failures++;
                $display("FAIL full_seq step=%0d got=%b exp=%b", i, o1, exp[i]);
            end
            bus.data_in = 8'h3C;
        end
    endtask

    task automatic test_soft_reset();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h00;
        tick();
        tick();
        bus.soft_reset = 3'b010;
        tick();
        checks++;
        if (o1 !== S_LD) begin
            failures++;
            $display("FAIL srst_other got=%b exp=%b", o1, S_LD);
        end
        bus.soft_reset = 3'b001;
        tick();
        checks++;
        if (o1 !== S_DEC) begin
            failures++;
            $display("FAIL srst_own got=%b exp=%b", o1, S_DEC);
        end
        bus.soft_reset = 3'b000;
        bus.pkt_valid  = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h01;
        tick();
        tick();
        bus.fifo_full = 3'b010;
        tick();
        checks++;
        if (o1 !== S_FULL) begin
            failures++;
            $display("FAIL areset_pre got=%b exp=%b", o1, S_FULL);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({o1, bus.addr_q, bus.timeout} !== {S_DEC, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL areset_now got=%b/%0d/%b exp=%b/0/0", o1, bus.addr_q, bus.timeout, S_DEC);
        end
        bus.fifo_full = 3'b000;
        bus.pkt_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++;
        if (o1 !== S_DEC) begin
            failures++;
            $display("FAIL areset_after got=%b exp=%b", o1, S_DEC);
        end
    endtask

    initial begin
        bus.pkt_valid = 1'b0;  bus.data_in = '0;  bus.fifo_full = '0;
        bus.fifo_empty = 3'b111;  bus.soft_reset = '0;
        bus.parity_done = 1'b0;  bus.low_pkt_valid = 1'b0;
        bus2.pkt_valid = 1'b0; bus2.data_in = '0; bus2.fifo_full = '0;
        bus2.fifo_empty = 3'b111; bus2.soft_reset = '0;
        bus2.parity_done = 1'b0; bus2.low_pkt_valid = 1'b0;

        test_reset();
        test_basic();
        test_drop();
        test_wait_timeout();
        test_wait_max1();
        test_full();
        test_soft_reset();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
